// File: rtl/recebe_movimentos_uc.sv
// Move-string receiver control unit: parses ASCII cube moves from a serial
// receiver into a 32-entry FIFO, then dispatches them one at a time to a
// move executor over a valid/ready handshake.
module recebe_movimentos_uc (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx_pronto,
    input  logic [7:0] rx_dado,
    input  logic       move_ready,
    output logic       move_valid,
    output logic [2:0] move_face,
    output logic [1:0] move_giro,
    output logic [5:0] num_movimentos,
    output logic       ocupado,
    output logic       erro,
    output logic       fim_sequencia,
    output logic [3:0] db_estado
);

    localparam int DEPTH = 32;

    localparam logic [7:0] CH_APOS  = 8'h27;
    localparam logic [7:0] CH_DOIS  = 8'h32;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_HASH  = 8'h23;

    localparam logic [1:0] GIRO_CW  = 2'b01;
    localparam logic [1:0] GIRO_CCW = 2'b10;
    localparam logic [1:0] GIRO_DBL = 2'b11;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RECEBE   = 3'd1,
        DESPACHA = 3'd2,
        FIM      = 3'd3,
        ERRO     = 3'd4
    } state_t;

    typedef struct packed {
        logic [2:0] face;
        logic [1:0] giro;
    } move_t;

    state_t     state, state_nxt;
    move_t      fifo_mem [DEPTH];
    logic [4:0] wr_ptr, rd_ptr;
    logic [5:0] count;
    logic       fifo_full, fifo_empty;
    move_t      head;

    logic       pend_valid, pend_valid_nxt;
    move_t      pend, pend_nxt;

    logic       push, pop, clear, to_err;
    logic       is_face, is_term;
    logic [2:0] byte_face;

    assign fifo_full  = (count == 6'(DEPTH));
    assign fifo_empty = (count == 6'd0);
    assign head       = fifo_mem[rd_ptr];

    // Classify the incoming byte: face letter (with its code) or terminator.
    always_comb begin
        is_face   = 1'b1;
        byte_face = 3'd0;
        case (rx_dado)
            8'h55:   byte_face = 3'd0;  // U
            8'h44:   byte_face = 3'd1;  // D
            8'h4C:   byte_face = 3'd2;  // L
            8'h52:   byte_face = 3'd3;  // R
            8'h46:   byte_face = 3'd4;  // F
            8'h42:   byte_face = 3'd5;  // B
            default: is_face   = 1'b0;
        endcase
        is_term = (rx_dado == CH_LF) || (rx_dado == CH_HASH);
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state, FIFO push/pop and pending-move update.
    // A commit needing room in a full FIFO funnels into to_err, which
    // overrides everything else and wipes the buffered sequence.
    always_comb begin
        state_nxt      = state;
        pend_valid_nxt = pend_valid;
        pend_nxt       = pend;
        push           = 1'b0;
        pop            = 1'b0;
        clear          = 1'b0;
        to_err         = 1'b0;

        case (state)
            IDLE, RECEBE: begin
                if (rx_pronto) begin
                    if (is_face) begin
                        if (pend_valid && fifo_full) begin
                            to_err = 1'b1;
                        end else begin
                            push           = pend_valid;
                            pend_valid_nxt = 1'b1;
                            pend_nxt.face  = byte_face;
                            pend_nxt.giro  = GIRO_CW;
                            state_nxt      = RECEBE;
                        end
                    end else if (rx_dado == CH_APOS || rx_dado == CH_DOIS) begin
                        // A modifier only applies once, to a plain clockwise move.
                        if (pend_valid && pend.giro == GIRO_CW)
                            pend_nxt.giro = (rx_dado == CH_APOS) ? GIRO_CCW : GIRO_DBL;
                        else
                            to_err = 1'b1;
                    end else if (rx_dado == CH_SPACE) begin
                        if (pend_valid && fifo_full) begin
                            to_err = 1'b1;
                        end else begin
                            push           = pend_valid;
                            pend_valid_nxt = 1'b0;
                        end
                    end else if (rx_dado == CH_CR) begin
                        pend_valid_nxt = pend_valid;
                    end else if (is_term) begin
                        if (pend_valid && fifo_full) begin
                            to_err = 1'b1;
                        end else begin
                            push           = pend_valid;
                            pend_valid_nxt = 1'b0;
                            state_nxt      = (!fifo_empty || pend_valid) ? DESPACHA : IDLE;
                        end
                    end else begin
                        to_err = 1'b1;
                    end
                end
            end
            DESPACHA: begin
                if (fifo_empty) begin
                    state_nxt = IDLE;
                end else if (move_ready) begin
                    pop = 1'b1;
                    if (count == 6'd1) state_nxt = FIM;
                end
            end
            FIM: state_nxt = IDLE;
            ERRO: begin
                if (rx_pronto && is_term) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        if (to_err) begin
            state_nxt      = ERRO;
            clear          = 1'b1;
            push           = 1'b0;
            pend_valid_nxt = 1'b0;
            pend_nxt       = '0;
        end
    end

    // FIFO pointers, occupancy and pending-move register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            pend_valid <= 1'b0;
            pend       <= '0;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            pend_valid <= 1'b0;
            pend       <= '0;
        end else begin
            pend_valid <= pend_valid_nxt;
            pend       <= pend_nxt;
            if (push) wr_ptr <= wr_ptr + 5'd1;
            if (pop)  rd_ptr <= rd_ptr + 5'd1;
            // push and pop live in different states, never both at once
            count <= count + {5'd0, push} - {5'd0, pop};
        end
    end

    // FIFO storage; contents are don't-care once pointers are reset.
    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_ptr] <= pend;
    end

    assign move_valid     = (state == DESPACHA) && !fifo_empty;
    assign move_face      = move_valid ? head.face : 3'd0;
    assign move_giro      = move_valid ? head.giro : 2'd0;
    assign num_movimentos = count;
    assign ocupado        = (state == DESPACHA) || (state == FIM);
    assign erro           = (state == ERRO);
    assign fim_sequencia  = (state == FIM);
    assign db_estado      = {1'b0, state};

endmodule

// File: tb/tb_recebe_movimentos_uc.sv
// Self-checking bench for recebe_movimentos_uc: table-driven byte vectors,
// directed multi-cycle sequences and randomized strings against a queue model.
module tb_recebe_movimentos_uc;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       rx_pronto = 1'b0;
    logic [7:0] rx_dado = 8'h00;
    logic       move_ready = 1'b0;
    logic       move_valid;
    logic [2:0] move_face;
    logic [1:0] move_giro;
    logic [5:0] num_movimentos;
    logic       ocupado, erro, fim_sequencia;
    logic [3:0] db_estado;

    int checks = 0;
    int errors = 0;

    always #10 clock = ~clock;

    recebe_movimentos_uc dut (
        .clock(clock), .reset(reset), .rx_pronto(rx_pronto), .rx_dado(rx_dado),
        .move_ready(move_ready), .move_valid(move_valid), .move_face(move_face),
        .move_giro(move_giro), .num_movimentos(num_movimentos), .ocupado(ocupado),
        .erro(erro), .fim_sequencia(fim_sequencia), .db_estado(db_estado)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Sequence kept as a queue of {face,giro}; mode uses the observable state codes.
    logic [4:0] m_q[$];
    bit         m_pv = 1'b0;
    logic [2:0] m_pf = 3'd0;
    logic [1:0] m_pg = 2'd0;
    int         m_st = 0;
    logic [7:0] face_chr [6] = '{8'h55, 8'h44, 8'h4C, 8'h52, 8'h46, 8'h42};

    task automatic m_error();
        m_q.delete();
        m_pv = 1'b0;
        m_st = 4;
    endtask

    task automatic m_commit(output bit ovf);
        ovf = 1'b0;
        if (m_pv) begin
            if (m_q.size() == 32) ovf = 1'b1;
            else begin
                m_q.push_back({m_pf, m_pg});
                m_pv = 1'b0;
            end
        end
    endtask

    task automatic m_byte(input logic [7:0] b);
        int  f;
        bit  ovf;
        bit  term;
        term = (b == 8'h0A) || (b == 8'h23);
        if (m_st == 4) begin
            if (term) m_st = 0;
            return;
        end
        if (m_st == 2 || m_st == 3) return;
        f = -1;
        for (int i = 0; i < 6; i++) if (b == face_chr[i]) f = i;
        if (f >= 0) begin
            m_commit(ovf);
            if (ovf) m_error();
            else begin
                m_pv = 1'b1; m_pf = 3'(f); m_pg = 2'd1; m_st = 1;
            end
        end else if (b == 8'h27 || b == 8'h32) begin
            if (m_pv && m_pg == 2'd1) m_pg = (b == 8'h27) ? 2'd2 : 2'd3;
            else m_error();
        end else if (b == 8'h20) begin
            m_commit(ovf);
            if (ovf) m_error();
        end else if (b == 8'h0D) begin
            m_st = m_st;
        end else if (term) begin
            m_commit(ovf);
            if (ovf) m_error();
            else m_st = (m_q.size() != 0) ? 2 : 0;
        end else begin
            m_error();
        end
    endtask

    task automatic check_outputs(input string tag);
        logic       exp_mv;
        logic [2:0] exp_f;
        logic [1:0] exp_g;
        exp_mv = (m_st == 2) && (m_q.size() != 0);
        exp_f  = 3'd0;
        exp_g  = 2'd0;
        if (exp_mv) begin
            exp_f = m_q[0][4:2];
            exp_g = m_q[0][1:0];
        end
        chk({tag, " move_valid"}, 32'(move_valid), 32'(exp_mv));
        chk({tag, " move_face"}, 32'(move_face), 32'(exp_f));
        chk({tag, " move_giro"}, 32'(move_giro), 32'(exp_g));
        chk({tag, " num_movimentos"}, 32'(num_movimentos), 32'(m_q.size()));
        chk({tag, " ocupado"}, 32'(ocupado), 32'(m_st == 2 || m_st == 3));
        chk({tag, " erro"}, 32'(erro), 32'(m_st == 4));
        chk({tag, " fim_sequencia"}, 32'(fim_sequencia), 32'(m_st == 3));
        chk({tag, " db_estado"}, 32'(db_estado), 32'(m_st));
    endtask

    // One byte with a one-cycle rx_pronto pulse; outputs checked one cycle later.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clock);
        rx_pronto = 1'b1;
        rx_dado   = b;
        @(negedge clock);
        rx_pronto = 1'b0;
        rx_dado   = 8'h00;
        m_byte(b);
        check_outputs("byte");
    endtask

    // Drain a dispatch with move_ready high pct% of cycles, checking every cycle.
    task automatic drain(input int pct);
        int guard;
        guard = 0;
        while ((m_st == 2 || m_st == 3) && guard < 500) begin
            move_ready = ($urandom_range(0, 99) < pct);
            if (m_st == 3) m_st = 0;
            else if (move_ready && m_q.size() != 0) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) m_st = 3;
            end
            @(negedge clock);
            check_outputs("drain");
            guard++;
        end
        move_ready = 1'b0;
        if (guard >= 500) begin
            checks++;
            errors++;
            $display("FAIL drain bound: got %0d cycles, expected under 500", guard);
        end
    endtask

    typedef struct {
        logic [7:0] b;
        logic [5:0] num;
        logic       err;
        logic [3:0] st;
    } vec_t;

    vec_t vecs[$];
    logic [7:0] alpha [16] = '{8'h55, 8'h44, 8'h4C, 8'h52, 8'h46, 8'h42, 8'h52, 8'h46,
                               8'h27, 8'h27, 8'h32, 8'h32, 8'h20, 8'h20, 8'h0D, 8'h78};

    initial begin
        // reset state
        #5;
        chk("rst move_valid", 32'(move_valid), 0);
        chk("rst num", 32'(num_movimentos), 0);
        chk("rst db_estado", 32'(db_estado), 0);
        chk("rst erro", 32'(erro), 0);
        chk("rst ocupado", 32'(ocupado), 0);
        chk("rst fim", 32'(fim_sequencia), 0);
        #10 reset = 1'b1;

        // ---------------- table-driven vectors ----------------
        vecs.push_back('{8'h0A, 6'd0, 1'b0, 4'd0});  // LF in IDLE
        vecs.push_back('{8'h0D, 6'd0, 1'b0, 4'd0});
        vecs.push_back('{8'h20, 6'd0, 1'b0, 4'd0});
        vecs.push_back('{8'h52, 6'd0, 1'b0, 4'd1});  // R''\n
        vecs.push_back('{8'h27, 6'd0, 1'b0, 4'd1});
        vecs.push_back('{8'h27, 6'd0, 1'b1, 4'd4});
        vecs.push_back('{8'h0A, 6'd0, 1'b0, 4'd0});
        vecs.push_back('{8'h72, 6'd0, 1'b1, 4'd4});  // lowercase
        vecs.push_back('{8'h55, 6'd0, 1'b1, 4'd4});  // discarded in ERRO
        vecs.push_back('{8'h23, 6'd0, 1'b0, 4'd0});
        vecs.push_back('{8'h32, 6'd0, 1'b1, 4'd4});  // '2' in IDLE
        vecs.push_back('{8'h0A, 6'd0, 1'b0, 4'd0});
        vecs.push_back('{8'h46, 6'd0, 1'b0, 4'd1});  // F2' -> error
        vecs.push_back('{8'h32, 6'd0, 1'b0, 4'd1});
        vecs.push_back('{8'h27, 6'd0, 1'b1, 4'd4});
        vecs.push_back('{8'h23, 6'd0, 1'b0, 4'd0});
        vecs.push_back('{8'h52, 6'd0, 1'b0, 4'd1});  // "R U' F2\n"
        vecs.push_back('{8'h20, 6'd1, 1'b0, 4'd1});
        vecs.push_back('{8'h55, 6'd1, 1'b0, 4'd1});
        vecs.push_back('{8'h27, 6'd1, 1'b0, 4'd1});
        vecs.push_back('{8'h20, 6'd2, 1'b0, 4'd1});
        vecs.push_back('{8'h46, 6'd2, 1'b0, 4'd1});
        vecs.push_back('{8'h32, 6'd2, 1'b0, 4'd1});
        vecs.push_back('{8'h0A, 6'd3, 1'b0, 4'd2});
        foreach (vecs[i]) begin
            send_byte(vecs[i].b);
            chk($sformatf("vec%0d num", i), 32'(num_movimentos), 32'(vecs[i].num));
            chk($sformatf("vec%0d erro", i), 32'(erro), 32'(vecs[i].err));
            chk($sformatf("vec%0d db_estado", i), 32'(db_estado), 32'(vecs[i].st));
        end

        // dispatch of "R U' F2\n" with ready held high
        chk("seq1 face0", 32'(move_face), 3);
        chk("seq1 giro0", 32'(move_giro), 1);
        move_ready = 1'b1;
        @(negedge clock);
        chk("seq1 face1", 32'(move_face), 0);
        chk("seq1 giro1", 32'(move_giro), 2);
        chk("seq1 num1", 32'(num_movimentos), 2);
        @(negedge clock);
        chk("seq1 face2", 32'(move_face), 4);
        chk("seq1 giro2", 32'(move_giro), 3);
        @(negedge clock);
        chk("seq1 fim", 32'(fim_sequencia), 1);
        chk("seq1 db FIM", 32'(db_estado), 3);
        chk("seq1 valid in FIM", 32'(move_valid), 0);
        chk("seq1 num end", 32'(num_movimentos), 0);
        move_ready = 1'b0;
        @(negedge clock);
        chk("seq1 fim drop", 32'(fim_sequencia), 0);
        chk("seq1 db IDLE", 32'(db_estado), 0);
        m_q.delete(); m_pv = 1'b0; m_st = 0;

        // ---------------- "RU#" with backpressure, byte dropped in DESPACHA --------
        send_byte(8'h52); send_byte(8'h55); send_byte(8'h23);
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin rx_pronto = 1'b1; rx_dado = 8'h44; end
            @(negedge clock);
            rx_pronto = 1'b0;
            chk($sformatf("hold%0d valid", i), 32'(move_valid), 1);
            chk($sformatf("hold%0d face", i), 32'(move_face), 3);
            chk($sformatf("hold%0d giro", i), 32'(move_giro), 1);
            chk($sformatf("hold%0d num", i), 32'(num_movimentos), 2);
        end
        move_ready = 1'b1;
        @(negedge clock);
        chk("hold next face", 32'(move_face), 0);
        chk("hold next num", 32'(num_movimentos), 1);
        @(negedge clock);
        chk("hold fim", 32'(fim_sequencia), 1);
        move_ready = 1'b0;
        @(negedge clock);
        chk("hold idle", 32'(db_estado), 0);
        m_q.delete(); m_pv = 1'b0; m_st = 0;

        // ---------------- overflow: 33 "F " pairs ----------------
        for (int i = 0; i < 33; i++) begin
            send_byte(8'h46);
            send_byte(8'h20);
            if (i == 31) chk("ovf num32", 32'(num_movimentos), 32);
        end
        chk("ovf erro", 32'(erro), 1);
        chk("ovf num0", 32'(num_movimentos), 0);
        send_byte(8'h0A);
        chk("ovf recover db", 32'(db_estado), 0);
        chk("ovf recover erro", 32'(erro), 0);
        send_byte(8'h0A);
        chk("lf idle db", 32'(db_estado), 0);
        chk("lf idle valid", 32'(move_valid), 0);

        // ---------------- async reset mid-DESPACHA ----------------
        send_byte(8'h46); send_byte(8'h55); send_byte(8'h44);
        send_byte(8'h4C); send_byte(8'h52); send_byte(8'h0A);
        chk("rst5 num", 32'(num_movimentos), 5);
        @(negedge clock);
        #3 reset = 1'b0;
        #1;
        chk("arst valid", 32'(move_valid), 0);
        chk("arst face", 32'(move_face), 0);
        chk("arst giro", 32'(move_giro), 0);
        chk("arst num", 32'(num_movimentos), 0);
        chk("arst ocupado", 32'(ocupado), 0);
        chk("arst db", 32'(db_estado), 0);
        chk("arst fim", 32'(fim_sequencia), 0);
        m_q.delete(); m_pv = 1'b0; m_st = 0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_outputs("post-rst");
        send_byte(8'h42); send_byte(8'h0A);
        chk("B face", 32'(move_face), 5);
        chk("B giro", 32'(move_giro), 1);
        drain(100);

        // ---------------- randomized strings vs model ----------------
        for (int it = 0; it < 40; it++) begin
            int len;
            len = $urandom_range(1, 10);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 15) == 0) send_byte(($urandom_range(0, 1) == 0) ? 8'h0A : 8'h23);
                else send_byte(alpha[$urandom_range(0, 15)]);
            end
            send_byte(($urandom_range(0, 1) == 0) ? 8'h0A : 8'h23);
            if (m_st == 2) drain($urandom_range(30, 100));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
